mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, word-address width of the data RAM.
REQ-002 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  in  1  MEM-stage request present.
REQ-005 SHALL have port: req_ready  out  1  unit idle, request accepted when req_valid&&req_ready.
REQ-006 SHALL have ports: MemWrite, MemtoReg, MemtoRegSign  in  1 each  decoded control from ControlUnit.
REQ-007 SHALL have port: MemOp  in  3  size: 001 byte, 010 half, 100 word, 000 none.
REQ-008 SHALL have ports: addr  in  32  byte address; wdata  in  32  store data (rt).
REQ-009 SHALL have ports: rsp_valid  out  1  one-cycle completion pulse; rdata  out  32  load result; rsp_err  out  1  misaligned access.
REQ-010 SHALL have ports: ram_en  out  1; ram_we  out  1; ram_addr  out  ADDR_W  word address (addr[ADDR_W+1:2]); ram_wdata  out  32; ram_rdata  in  32, valid the cycle after ram_en&&!ram_we.

Function
REQ-011 SHALL implement states IDLE, RD, RDW, WR, RESP; req_ready=1 only in IDLE.
REQ-012 SHALL latch addr, wdata, MemOp, MemWrite, MemtoReg, MemtoRegSign on acceptance; inputs ignored outside IDLE.
REQ-013 SHALL classify accepted request: store if MemWrite=1 (priority over MemtoReg), load if MemtoReg=1, else no-op.
REQ-014 SHALL route: load IDLE->RD->RDW->RESP (rsp_valid at T+3 after accept cycle T); word store IDLE->WR->RESP (T+2); byte/half store IDLE->RD->RDW->WR->RESP (read-modify-write, T+4); no-op or MemOp=000 IDLE->RESP (T+1).
REQ-015 SHALL drive ram_en=1,ram_we=0 only in RD; ram_en=1,ram_we=1 only in WR; both 0 elsewhere.
REQ-016 SHALL use little-endian lanes: byte n = bits[8n+7:8n] for addr[1:0]=n; half h = bits[16h+15:16h] for addr[1]=h.
REQ-017 SHALL, on load in RDW, register rdata = selected lane sign-extended if MemtoRegSign=1 else zero-extended; word loads pass 32 bits.
REQ-018 SHALL, on RMW in RDW, register ram_wdata = ram_rdata with selected lane replaced by wdata low byte/half; word store ram_wdata=wdata.
REQ-019 SHALL hold rdata stable from RESP until the next load's RESP; store and no-op leave rdata unchanged.
REQ-020 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; back-to-back accept allowed the cycle after RESP.
REQ-021 SHALL treat an illegal MemOp (not 000/001/010/100) as no-op with rsp_err=1.

Reset
REQ-022 SHALL, while reset=1, force state IDLE, rsp_valid=0, rsp_err=0, rdata=0, ram_en=0, ram_we=0, ram_wdata=0; req_ready=0 during reset.
REQ-023 SHALL abort any in-flight access on reset; no RAM write issued in or after the reset cycle for that request.

Configuration
REQ-024 SHALL support macro MEM_ACCESS_MISALIGN_TRAP_EN.
REQ-025 With MEM_ACCESS_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP, no RAM access, rsp_err=1, rdata unchanged.
REQ-026 Without it: low address bits below access size SHALL be forced to 0, access proceeds normally, rsp_err only from REQ-021.

Structure
REQ-027 SHALL place MemOp encodings (MEMOP_NONE/BYTE/HALF/WORD) and state encodings in shared package mips_pkg, also used by ControlUnit.
REQ-028 SHALL isolate lane extract/extend and lane merge in combinational sub-module mem_lane_align.

Verification
REQ-029 LW addr=0x8, RAM word2=0x8765_4321 -> rsp_valid at T+3, rdata=0x8765_4321, rsp_err=0, one read only.
REQ-030 LB addr=0x7 (sign), RAM word1=0x80FF_0000 -> rdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-031 SH addr=0x6, wdata=0x1234_ABCD, RAM word1=0x1111_2222 -> read then write 0xABCD_2222, rsp_valid at T+4.
REQ-032 SW addr=0x4 wdata=0xDEAD_BEEF -> single write at T+1, no read, rsp_valid at T+2.
REQ-033 LW addr=0x6 with MEM_ACCESS_MISALIGN_TRAP_EN -> no ram_en, rsp_err=1 at T+1; without macro -> reads word1, rsp_err=0.
REQ-034 SB accepted, reset asserted in RDW -> no ram_we ever, state IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: MemOp sizes, MEM-stage access states and access kinds.
// Also imported by ControlUnit so both sides agree on the MemOp encoding.
package mips_pkg;

  localparam logic [2:0] MEMOP_NONE = 3'b000;
  localparam logic [2:0] MEMOP_BYTE = 3'b001;
  localparam logic [2:0] MEMOP_HALF = 3'b010;
  localparam logic [2:0] MEMOP_WORD = 3'b100;

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} mem_state_e;
  typedef enum logic [1:0] {ACC_NOP, ACC_LOAD, ACC_STORE} acc_kind_e;

  function automatic logic memop_legal(input logic [2:0] op);
    return (op == MEMOP_NONE) || (op == MEMOP_BYTE) ||
           (op == MEMOP_HALF) || (op == MEMOP_WORD);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  boff,
  input  logic        sign,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [4:0]  bsh;
  logic [4:0]  hsh;

  assign bsh = {boff, 3'b000};
  assign hsh = {boff[1], 4'b0000};

  always_comb begin
    lane8    = rword[bsh +: 8];
    lane16   = rword[hsh +: 16];
    load_val = rword;
    merged   = wdata;
    case (op)
      MEMOP_BYTE: begin
        load_val = sign ? {{24{lane8[7]}}, lane8} : {24'b0, lane8};
        merged   = rword;
        merged[bsh +: 8] = wdata[7:0];
      end
      MEMOP_HALF: begin
        load_val = sign ? {{16{lane16[15]}}, lane16} : {16'b0, lane16};
        merged   = rword;
        merged[hsh +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data RAM sequencer: loads, word stores, sub-word read-modify-write.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word instead of aligning down.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              MemtoRegSign,
  input  logic [2:0]        MemOp,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mem_state_e        state_q, state_d;
  acc_kind_e         kind_q, kind_in;
  logic [ADDR_W+1:0] addr_q, addr_in;
  logic [31:0]       wdata_q, rdata_q, ram_wdata_q;
  logic [2:0]        op_q;
  logic              sign_q, err_q, err_in;
  logic              accept, legal, misal;
  logic [31:0]       load_val, merged;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];
  assign accept      = req_valid && (state_q == IDLE);
  assign legal       = memop_legal(MemOp);
  assign misal       = ((MemOp == MEMOP_HALF) && addr[0]) ||
                       ((MemOp == MEMOP_WORD) && (addr[1:0] != 2'b00));

  // Aligning down is harmless under the trap build: misaligned requests never reach the RAM.
  always_comb begin
    addr_in = addr[ADDR_W+1:0];
    if (MemOp == MEMOP_HALF) addr_in[0] = 1'b0;
    if (MemOp == MEMOP_WORD) addr_in[1:0] = 2'b00;
    err_in  = !legal;
    kind_in = ACC_NOP;
    if (legal && (MemOp != MEMOP_NONE)) begin
      if (MemWrite)      kind_in = ACC_STORE;
      else if (MemtoReg) kind_in = ACC_LOAD;
    end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if (misal && (kind_in != ACC_NOP)) begin
      kind_in = ACC_NOP;
      err_in  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        case (kind_in)
          ACC_LOAD:  state_d = RD;
          ACC_STORE: state_d = (MemOp == MEMOP_WORD) ? WR : RD;
          default:   state_d = RESP;
        endcase
      end
      RD:      state_d = RDW;
      RDW:     state_d = (kind_q == ACC_LOAD) ? RESP : WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_lane_align u_align (
    .op       (op_q),
    .boff     (addr_q[1:0]),
    .sign     (sign_q),
    .rword    (ram_rdata),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kind_q      <= ACC_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= MEMOP_NONE;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q  <= kind_in;
        addr_q  <= addr_in;
        wdata_q <= wdata;
        op_q    <= MemOp;
        sign_q  <= MemtoRegSign;
        err_q   <= err_in;
        if (kind_in == ACC_STORE && MemOp == MEMOP_WORD) ram_wdata_q <= wdata;
      end
      if (state_q == RDW) begin
        if (kind_q == ACC_LOAD) rdata_q <= load_val;
        else                    ram_wdata_q <= merged;
      end
    end
  end

  // Outputs are masked by reset so an in-flight access cannot write during the reset cycle.
  assign req_ready = !reset && (state_q == IDLE);
  assign rsp_valid = !reset && (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign ram_en    = !reset && ((state_q == RD) || (state_q == WR));
  assign ram_we    = !reset && (state_q == WR);
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign rdata     = reset ? 32'h0 : rdata_q;
  assign ram_wdata = reset ? 32'h0 : ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle-latency RAM model.
module tb_mem_access_unit;
  localparam int ADDR_W = 10;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic MemWrite = 1'b0, MemtoReg = 1'b0, MemtoRegSign = 1'b0;
  logic [2:0] MemOp = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic rsp_valid, rsp_err, ram_en, ram_we;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int nrd = 0, nwr = 0;
  logic pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int ntot = 0, nbad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .MemtoRegSign(MemtoRegSign),
    .MemOp(MemOp), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid),
    .rdata(rdata), .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_en && !ram_we) begin
      ram_rdata <= mem[ram_addr];
      nrd <= nrd + 1;
    end
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      nwr <= nwr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and waits for rsp_valid; lat is in cycles after the accept cycle.
  task automatic xact(input logic mw, input logic mr, input logic sg, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er,
                      output int drd, output int dwr);
    int rd0, wr0;
    @(negedge clk);
    req_valid = 1'b1; MemWrite = mw; MemtoReg = mr; MemtoRegSign = sg;
    MemOp = op; addr = a; wdata = wd;
    rd0 = nrd; wr0 = nwr;
    lat = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (rsp_valid) break;
      if (lat > 12) begin lat = 99; break; end
    end
    rd = rdata; er = rsp_err;
    drd = nrd - rd0; dwr = nwr - wr0;
  endtask

  initial begin
    int lat, drd, dwr, wr0;
    logic [31:0] rd;
    logic er;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rspv", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ramen", {30'b0, ram_en, ram_we}, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    preload(10'd2, 32'h8765_4321);
    preload(10'd1, 32'h80FF_0000);
    preload(10'd0, 32'h8001_7FFF);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'h1);

    xact(0, 1, 0, 3'b100, 32'h8, 0, lat, rd, er, drd, dwr);
    chk("lw_lat", lat, 3); chk("lw_data", rd, 32'h8765_4321);
    chk("lw_err", {31'b0, er}, 0); chk("lw_reads", drd, 1); chk("lw_writes", dwr, 0);

    xact(0, 1, 1, 3'b001, 32'h7, 0, lat, rd, er, drd, dwr);
    chk("lb_lat", lat, 3); chk("lb_data", rd, 32'hFFFF_FF80);
    xact(0, 1, 0, 3'b001, 32'h7, 0, lat, rd, er, drd, dwr);
    chk("lbu_data", rd, 32'h0000_0080);

    preload(10'd1, 32'h1111_2222);
    xact(1, 0, 0, 3'b010, 32'h6, 32'h1234_ABCD, lat, rd, er, drd, dwr);
    chk("sh_lat", lat, 4); chk("sh_reads", drd, 1); chk("sh_writes", dwr, 1);
    chk("sh_mem", mem[1], 32'hABCD_2222); chk("sh_rdata_kept", rd, 32'h0000_0080);

    xact(1, 0, 0, 3'b100, 32'h4, 32'hDEAD_BEEF, lat, rd, er, drd, dwr);
    chk("sw_lat", lat, 2); chk("sw_reads", drd, 0); chk("sw_writes", dwr, 1);
    chk("sw_mem", mem[1], 32'hDEAD_BEEF); chk("sw_rdata_kept", rd, 32'h0000_0080);

    xact(0, 1, 0, 3'b100, 32'h6, 0, lat, rd, er, drd, dwr);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("mis_lat", lat, 1); chk("mis_err", {31'b0, er}, 1);
    chk("mis_reads", drd, 0); chk("mis_rdata", rd, 32'h0000_0080);
`else
    chk("mis_lat", lat, 3); chk("mis_err", {31'b0, er}, 0);
    chk("mis_reads", drd, 1); chk("mis_rdata", rd, 32'hDEAD_BEEF);
`endif

    xact(0, 1, 0, 3'b011, 32'h0, 0, lat, rd, er, drd, dwr);
    chk("ill_lat", lat, 1); chk("ill_err", {31'b0, er}, 1); chk("ill_reads", drd, 0);

    xact(0, 0, 0, 3'b100, 32'h0, 0, lat, rd, er, drd, dwr);
    chk("nop_lat", lat, 1); chk("nop_err", {31'b0, er}, 0); chk("nop_ram", drd + dwr, 0);

    xact(0, 1, 1, 3'b010, 32'h2, 0, lat, rd, er, drd, dwr);
    chk("lh_data", rd, 32'hFFFF_8001);
    xact(0, 1, 0, 3'b010, 32'h0, 0, lat, rd, er, drd, dwr);
    chk("lhu_data", rd, 32'h0000_7FFF);

    xact(1, 1, 0, 3'b001, 32'h5, 32'h0000_00AA, lat, rd, er, drd, dwr);
    chk("sb_lat", lat, 4); chk("sb_mem", mem[1], 32'hDEAD_AAEF);
    chk("sb_rdata_kept", rd, 32'h0000_7FFF);

    // SB interrupted by reset while in RDW
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; MemtoReg = 1'b0; MemOp = 3'b001;
    addr = 32'h4; wdata = 32'h55;
    wr0 = nwr;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rstmid_ramwe", {30'b0, ram_en, ram_we}, 0);
    chk("rstmid_ready", {31'b0, req_ready}, 0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("after_rst_ready", {31'b0, req_ready}, 1);
    chk("after_rst_rdata", rdata, 0);
    chk("after_rst_wdata", ram_wdata, 0);
    chk("after_rst_out", {29'b0, rsp_valid, rsp_err, ram_en}, 0);
    repeat (4) @(negedge clk);
    chk("rst_no_write", nwr - wr0, 0);
    chk("rst_mem_kept", mem[1], 32'hDEAD_AAEF);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
